// File: rtl/uart_apb_master.sv
// UART-to-APB bridge master.
// Parses command frames from a byte stream, runs one APB transfer per frame,
// and returns a status byte (plus read data for reads) to the UART transmitter.
module uart_apb_master #(
   parameter int APB_TO  = 1023,
   parameter int BYTE_TO = 65535
) (
   input  logic        i_uart_clk,
   input  logic        i_uart_rst_n,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_vld,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_vld,
   input  logic        i_tx_rdy,
   output logic        o_uart_p_sel,
   output logic        o_uart_p_ce,
   output logic        o_uart_p_we,
   output logic [3:0]  o_uart_p_strb,
   output logic [15:0] o_uart_p_addr,
   output logic [31:0] o_uart_p_wdata,
   input  logic        i_uart_p_rdy,
   input  logic [31:0] i_uart_p_rdata,
   output logic        o_busy,
   output logic        o_rx_drop
);

   localparam int AW = (APB_TO  < 1) ? 1 : $clog2(APB_TO + 1);
   localparam int BW = (BYTE_TO < 1) ? 1 : $clog2(BYTE_TO + 1);
   localparam logic [AW-1:0] APB_LIMIT  = AW'(APB_TO);
   localparam logic [BW-1:0] BYTE_LIMIT = BW'(BYTE_TO);

   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;
   localparam logic [7:0] ST_OK  = 8'h00;
   localparam logic [7:0] ST_TO  = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      RX_FRAME,
      SETUP,
      ACCESS,
      TX_RESP
   } state_t;

   state_t          state;
   logic [2:0]      byte_idx;
   logic            frame_wr;
   logic [15:0]     frame_addr;
   logic [3:0]      frame_strb;
   logic [31:0]     frame_wdata;
   logic [BW-1:0]   byte_cnt;
   logic [AW-1:0]   apb_cnt;
   logic [31:0]     resp_data;
   logic [2:0]      tx_left;
   logic            last_byte;

   // A read frame ends on its address low byte, a write frame on its last data byte.
   assign last_byte = frame_wr ? (byte_idx == 3'd7) : (byte_idx == 3'd2);
   assign o_busy    = (state != IDLE);

   // Frame parser, APB sequencer and response serializer in one registered FSM.
   always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
      if (!i_uart_rst_n) begin
         state          <= IDLE;
         byte_idx       <= 3'd0;
         frame_wr       <= 1'b0;
         frame_addr     <= 16'h0;
         frame_strb     <= 4'h0;
         frame_wdata    <= 32'h0;
         byte_cnt       <= '0;
         apb_cnt        <= '0;
         resp_data      <= 32'h0;
         tx_left        <= 3'd0;
         o_tx_data      <= 8'h0;
         o_tx_vld       <= 1'b0;
         o_uart_p_sel   <= 1'b0;
         o_uart_p_ce    <= 1'b0;
         o_uart_p_we    <= 1'b0;
         o_uart_p_strb  <= 4'h0;
         o_uart_p_addr  <= 16'h0;
         o_uart_p_wdata <= 32'h0;
         o_rx_drop      <= 1'b0;
      end else begin
         o_rx_drop <= 1'b0;
         case (state)
            IDLE: begin
               if (i_rx_vld) begin
                  if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
                     frame_wr    <= (i_rx_data == CMD_WR);
                     byte_idx    <= 3'd1;
                     byte_cnt    <= '0;
                     frame_strb  <= 4'h0;
                     frame_wdata <= 32'h0;
                     state       <= RX_FRAME;
                  end else begin
                     o_rx_drop <= 1'b1;
                  end
               end
            end

            RX_FRAME: begin
               if (i_rx_vld) begin
                  byte_cnt <= '0;
                  case (byte_idx)
                     3'd1:    frame_addr[15:8] <= i_rx_data;
                     3'd2:    frame_addr[7:0]  <= i_rx_data;
                     3'd3:    frame_strb       <= i_rx_data[3:0];
                     default: frame_wdata      <= {frame_wdata[23:0], i_rx_data};
                  endcase
                  if (last_byte) begin
                     // Load the bus from the byte arriving now so SETUP already sees the full frame.
                     byte_idx       <= 3'd0;
                     o_uart_p_sel   <= 1'b1;
                     o_uart_p_we    <= frame_wr;
                     o_uart_p_addr  <= frame_wr ? frame_addr : {frame_addr[15:8], i_rx_data};
                     o_uart_p_strb  <= frame_wr ? frame_strb : 4'h0;
                     o_uart_p_wdata <= frame_wr ? {frame_wdata[23:0], i_rx_data} : 32'h0;
                     state          <= SETUP;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                  end
               end else if (byte_cnt == BYTE_LIMIT) begin
                  // Sender went quiet mid-frame: forget the partial frame silently.
                  byte_idx <= 3'd0;
                  state    <= IDLE;
               end else begin
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end

            SETUP: begin
               if (i_rx_vld) o_rx_drop <= 1'b1;
               o_uart_p_ce <= 1'b1;
               apb_cnt     <= '0;
               state       <= ACCESS;
            end

            ACCESS: begin
               if (i_rx_vld) o_rx_drop <= 1'b1;
               if (i_uart_p_rdy || apb_cnt == APB_LIMIT) begin
                  // A ready slave wins over a timeout landing on the same cycle.
                  o_uart_p_sel <= 1'b0;
                  o_uart_p_ce  <= 1'b0;
                  o_uart_p_we  <= 1'b0;
                  o_tx_vld     <= 1'b1;
                  o_tx_data    <= i_uart_p_rdy ? ST_OK : ST_TO;
                  resp_data    <= (i_uart_p_rdy && !frame_wr) ? i_uart_p_rdata : 32'h0;
                  tx_left      <= frame_wr ? 3'd0 : 3'd4;
                  state        <= TX_RESP;
               end else begin
                  apb_cnt <= apb_cnt + 1'b1;
               end
            end

            TX_RESP: begin
               if (i_rx_vld) o_rx_drop <= 1'b1;
               if (i_tx_rdy) begin
                  if (tx_left == 3'd0) begin
                     o_tx_vld  <= 1'b0;
                     o_tx_data <= 8'h0;
                     state     <= IDLE;
                  end else begin
                     o_tx_data <= resp_data[31:24];
                     resp_data <= {resp_data[23:0], 8'h0};
                     tx_left   <= tx_left - 3'd1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: ipsl_pcie_uart_apb_master

Interface
REQ-001 SHALL have parameter APB_TO, default 1023, max cycles to wait for i_uart_p_rdy in access phase.
REQ-002 SHALL have parameter BYTE_TO, default 65535, max idle cycles between bytes of one frame.
REQ-003 SHALL have one clock, i_uart_clk, input 1, all logic on rising edge.
REQ-004 SHALL have i_uart_rst_n, input 1, reset, asynchronous and active-low.
REQ-005 SHALL have i_rx_data, input 8, received UART byte.
REQ-006 SHALL have i_rx_vld, input 1, one-cycle strobe qualifying i_rx_data.
REQ-007 SHALL have o_tx_data, output 8, response byte to UART transmitter.
REQ-008 SHALL have o_tx_vld, output 1, response byte valid.
REQ-009 SHALL have i_tx_rdy, input 1, transmitter accepts byte when high with o_tx_vld.
REQ-010 SHALL have o_uart_p_sel, o_uart_p_ce, o_uart_p_we, outputs 1 each, APB select, enable (access phase), write.
REQ-011 SHALL have o_uart_p_strb, output 4, o_uart_p_addr, output 16, o_uart_p_wdata, output 32, APB strobe/address/write data.
REQ-012 SHALL have i_uart_p_rdy, input 1, and i_uart_p_rdata, input 32, APB ready and read data from the APB mux.
REQ-013 SHALL have o_busy, output 1, high in any state except IDLE; o_rx_drop, output 1, one-cycle pulse per discarded byte.

Function
REQ-014 SHALL parse frames: byte0 cmd (0x01 write, 0x02 read), byte1 addr[15:8], byte2 addr[7:0]; write adds byte3 strb (bits[3:0], bits[7:4] ignored) and bytes4-7 wdata MSB first.
REQ-015 SHALL discard byte0 values other than 0x01/0x02 in IDLE, pulse o_rx_drop, stay in IDLE.
REQ-016 SHALL use states IDLE, RX_FRAME, SETUP, ACCESS, TX_RESP.
REQ-017 IDLE -> RX_FRAME on valid cmd byte; RX_FRAME -> SETUP the cycle after the last frame byte (byte2 read, byte7 write).
REQ-018 SHALL count idle cycles in RX_FRAME; at count == BYTE_TO with no byte, drop partial frame, return to IDLE, send no response.
REQ-019 SETUP: exactly one cycle sel=1, ce=0; addr/strb/wdata/we stable from SETUP to end of ACCESS; read sets we=0, strb=4'h0, wdata=0.
REQ-020 ACCESS: sel=1, ce=1 until i_uart_p_rdy sampled high; in that cycle capture i_uart_p_rdata (read) and set status 0x00; sel/ce low next cycle, go TX_RESP.
REQ-021 ACCESS wait counter SHALL start at 0 on ACCESS entry; if rdy still low when count reaches APB_TO, abort: sel/ce low next cycle, status 0xFF, read data 0x00000000, go TX_RESP.
REQ-022 Write response SHALL be 1 byte: status; read response SHALL be 5 bytes: status, then rdata[31:24], [23:16], [15:8], [7:0].
REQ-023 o_tx_vld/o_tx_data SHALL hold stable until the cycle i_tx_rdy=1; next byte may present the following cycle; after last accepted byte go IDLE.
REQ-024 i_rx_vld bytes arriving in SETUP, ACCESS or TX_RESP SHALL be discarded with o_rx_drop pulse; state unaffected.
REQ-025 All APB and TX outputs SHALL be registered; o_uart_p_sel, o_uart_p_ce, o_uart_p_we low outside SETUP/ACCESS.
REQ-026 Minimum latency: last rx byte to first o_tx_vld = 3 cycles when rdy is high on first ACCESS cycle.

Reset
REQ-027 On i_uart_rst_n low, immediately: state IDLE, all outputs 0 (sel, ce, we, strb, addr, wdata, tx_vld, tx_data, busy, rx_drop), counters and byte index 0.
REQ-028 Reset asserted mid-frame, mid-access or mid-response SHALL abandon the transaction; no residual byte sent after release.
REQ-029 First byte accepted the first clock edge after reset deassertion.

Verification
REQ-030 Write: rx 01 70 04 0F 12 34 56 78, rdy high after 2 ACCESS cycles -> addr 0x7004, strb 0xF, wdata 0x12345678, we=1, one SETUP cycle, tx byte 0x00.
REQ-031 Read: rx 02 10 20, rdy with rdata 0xCAFEBABE -> addr 0x1020, we=0, tx 00 CA FE BA BE; i_tx_rdy toggled 1/0 so each byte held while rdy low.
REQ-032 Timeout: read to 0x3000, rdy never high -> ACCESS lasts APB_TO+1 cycles, tx FF 00 00 00 00, state IDLE after.
REQ-033 Junk/interleave: rx 0x55 in IDLE -> o_rx_drop pulse, no APB; bytes during ACCESS -> dropped, transaction completes normally.
REQ-034 Inter-byte timeout (BYTE_TO=16): rx 01 70 then silence 17 cycles -> IDLE, no APB, no tx; following frame 02 70 00 handled correctly.
REQ-035 Reset in ACCESS: assert i_uart_rst_n low -> sel/ce/tx_vld 0 same cycle; after release, new write frame completes with status 0x00.
